// File: rtl/dcache_sram_bridge.sv
// MEM-stage data port to SRAM-like bus bridge: one registered transaction per
// request with addr_ok/data_ok handshake, holding the pipeline until done.
module dcache_sram_bridge #(
    parameter bit KSEG_MAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  d_en,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_size,
    input  logic [3:0]  w_byte_select,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

    state_e      r_state;
    logic        w_req;
    logic [31:0] w_paddr;

    assign w_req = (d_en == 2'b01) || (d_en == 2'b10);

    // kseg0/kseg1 (addr[31:29] = 100/101) fold onto the low 512 MiB
    always_comb begin
        w_paddr = d_addr;
        if (KSEG_MAP && (d_addr[31:30] == 2'b10)) begin
            w_paddr = {3'b000, d_addr[28:0]};
        end
    end

    always_comb begin
        d_stall = 1'b0;
        unique case (r_state)
            StIdle:  d_stall = w_req;
            StAddr:  d_stall = 1'b1;
            StData:  d_stall = 1'b1;
            StDone:  d_stall = 1'b0;
            default: d_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'b00;
            data_addr  <= 32'h0;
            data_wdata <= 32'h0;
            data_wstrb <= 4'h0;
            d_rdata    <= 32'h0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_req) begin
                        r_state    <= StAddr;
                        data_req   <= 1'b1;
                        data_wr    <= d_en[1];
                        data_size  <= d_size[1:0];
                        data_addr  <= w_paddr;
                        data_wdata <= d_wdata;
                        data_wstrb <= d_en[1] ? w_byte_select : 4'h0;
                    end
                end
                StAddr: begin
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        if (data_data_ok) begin
                            if (!data_wr) begin
                                d_rdata <= data_rdata;
                            end
                            r_state <= StDone;
                        end else begin
                            r_state <= StData;
                        end
                    end
                end
                StData: begin
                    if (data_data_ok) begin
                        if (!data_wr) begin
                            d_rdata <= data_rdata;
                        end
                        r_state <= StDone;
                    end
                end
                // d_en is still held by the completing instruction; never recapture here
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_sram_bridge.sv
// Scoreboard bench for dcache_sram_bridge: stimulus pushes expected bus requests
// and completions; negedge monitors pop and compare.
module tb_dcache_sram_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  d_en = 2'b00;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [2:0]  d_size = 3'b000;
    logic [3:0]  w_byte_select = 4'h0;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'h0;
    logic [31:0] d_rdata;
    logic        d_stall, data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;

    // second instance without kseg translation
    logic [1:0]  k_en = 2'b00;
    logic [31:0] k_addr = 32'h0;
    logic [2:0]  k_size = 3'b000;
    logic        k_aok = 1'b0;
    logic        k_dok = 1'b0;
    logic [31:0] k_rdata, k_baddr, k_bwdata;
    logic        k_stall, k_req, k_wr;
    logic [1:0]  k_bsize;
    logic [3:0]  k_wstrb;

    always #5 clk = ~clk;

    dcache_sram_bridge #(.KSEG_MAP(1'b1)) u_dut (
        .clk(clk), .rst(rst), .d_en(d_en), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .w_byte_select(w_byte_select), .d_rdata(d_rdata),
        .d_stall(d_stall), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    dcache_sram_bridge #(.KSEG_MAP(1'b0)) u_dut_nomap (
        .clk(clk), .rst(rst), .d_en(k_en), .d_addr(k_addr), .d_wdata(32'h0),
        .d_size(k_size), .w_byte_select(4'h0), .d_rdata(k_rdata),
        .d_stall(k_stall), .data_req(k_req), .data_wr(k_wr), .data_size(k_bsize),
        .data_addr(k_baddr), .data_wdata(k_bwdata), .data_wstrb(k_wstrb),
        .data_addr_ok(k_aok), .data_data_ok(k_dok), .data_rdata(32'h0)
    );

    typedef struct {
        logic [70:0] bus;   // {wr, size, addr, wdata, wstrb}
        int          reqc;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        int          stalls;
    } done_exp_t;

    bus_exp_t    exp_bus[$];
    done_exp_t   exp_done[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_rd = 32'h0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus request monitor: fields must match and stay stable until addr_ok
    int req_cnt = 0;
    always @(negedge clk) begin
        if (!rst && data_req) begin
            if (exp_bus.size() == 0) begin
                chk("unexpected_req", {data_wr, data_addr}, 128'h0);
            end else begin
                req_cnt++;
                chk("req_fields", {data_wr, data_size, data_addr, data_wdata, data_wstrb},
                    exp_bus[0].bus);
                if (data_addr_ok) begin
                    chk("req_cycles", req_cnt, exp_bus[0].reqc);
                    void'(exp_bus.pop_front());
                    req_cnt = 0;
                end
            end
        end
    end

    // Completion monitor: falling d_stall marks the DONE cycle
    int stall_run = 0;
    always @(negedge clk) begin
        if (rst) begin
            stall_run = 0;
        end else if (d_stall) begin
            stall_run++;
            if (stall_run == 100) begin
                chk("stall_timeout", stall_run, 0);
            end
        end else if (stall_run > 0) begin
            if (exp_done.size() == 0) begin
                chk("unexpected_done", stall_run, 0);
            end else begin
                chk("done_rdata", d_rdata, exp_done[0].rdata);
                chk("done_stalls", stall_run, exp_done[0].stalls);
                void'(exp_done.pop_front());
            end
            stall_run = 0;
        end
    end

    // One transaction; aw = cycles without addr_ok, dw = cycles after addr_ok until data_ok
    task automatic do_txn(input logic [1:0] en, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] sz, input logic [3:0] bsel, input int aw,
                          input int dw, input logic [31:0] rd, input logic [31:0] exp_addr);
        bus_exp_t  be;
        done_exp_t de;
        be.bus  = {en[1], sz[1:0], exp_addr, wd, (en == 2'b10) ? bsel : 4'h0};
        be.reqc = aw + 1;
        if (en == 2'b01) model_rd = rd;
        de.rdata  = model_rd;
        de.stalls = 1 + (aw + 1) + dw;
        exp_bus.push_back(be);
        exp_done.push_back(de);
        d_en = en; d_addr = addr; d_wdata = wd; d_size = sz; w_byte_select = bsel;
        tick();
        for (int i = 0; i < aw; i++) tick();
        data_addr_ok = 1'b1;
        data_data_ok = (dw == 0);
        data_rdata   = (dw == 0) ? rd : 32'h1111_1111;
        tick();
        data_addr_ok = 1'b0;
        if (dw > 0) begin
            data_data_ok = 1'b0;
            for (int i = 1; i < dw; i++) tick();
            data_data_ok = 1'b1;
            data_rdata   = rd;
            tick();
        end
        data_data_ok = 1'b0;
        data_rdata   = 32'h2222_2222;
        tick();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", data_req, 0);
        chk("rst_wr", data_wr, 0);
        chk("rst_size", data_size, 0);
        chk("rst_addr", data_addr, 0);
        chk("rst_wdata", data_wdata, 0);
        chk("rst_wstrb", data_wstrb, 0);
        chk("rst_rdata", d_rdata, 0);
        chk("rst_stall", d_stall, 0);
        tick();

        // load word through kseg0, single-cycle handshake
        do_txn(2'b01, 32'h8000_1004, 32'h0, 3'b010, 4'h0, 0, 0, 32'hDEAD_BEEF, 32'h0000_1004);
        d_en = 2'b00;
        tick();
        // store byte through kseg1, addr_ok after 3 waits, data_ok 2 later
        do_txn(2'b10, 32'hA000_0003, 32'h5A5A_5A5A, 3'b000, 4'b1000, 3, 2, 32'h3333_3333,
               32'h0000_0003);
        d_en = 2'b00;
        tick();
        // back-to-back loads: second request presented right after DONE
        do_txn(2'b01, 32'h0000_0010, 32'h0, 3'b010, 4'h0, 0, 1, 32'h1234_5678, 32'h0000_0010);
        do_txn(2'b01, 32'h9FFF_FFFC, 32'h0, 3'b011, 4'h0, 1, 0, 32'hCAFE_F00D, 32'h1FFF_FFFC);
        // unmapped high segment passes through, half store
        do_txn(2'b10, 32'hC000_0008, 32'hABCD_ABCD, 3'b001, 4'b0011, 0, 0, 32'h4444_4444,
               32'hC000_0008);
        d_en = 2'b00;

        // stray data_ok / addr_ok in IDLE, then illegal d_en
        data_data_ok = 1'b1; data_addr_ok = 1'b1; data_rdata = 32'h7777_7777;
        tick();
        data_data_ok = 1'b0; data_addr_ok = 1'b0;
        @(negedge clk);
        chk("stray_stall", d_stall, 0);
        chk("stray_req", data_req, 0);
        chk("stray_rdata", d_rdata, model_rd);
        d_en = 2'b11;
        tick();
        @(negedge clk);
        chk("illegal_stall", d_stall, 0);
        chk("illegal_req", data_req, 0);
        tick();
        d_en = 2'b00;
        do_txn(2'b01, 32'h0000_0100, 32'h0, 3'b010, 4'h0, 2, 3, 32'h5555_AAAA, 32'h0000_0100);
        d_en = 2'b00;
        tick();

        // KSEG_MAP=0 instance: load half at kseg0 address is not translated
        k_en = 2'b01; k_addr = 32'h8000_0002; k_size = 3'b001;
        tick();
        @(negedge clk);
        chk("nomap_req", k_req, 1);
        chk("nomap_addr", k_baddr, 32'h8000_0002);
        chk("nomap_size", k_bsize, 2'b01);
        chk("nomap_wstrb", k_wstrb, 0);
        k_aok = 1'b1; k_dok = 1'b1;
        tick();
        k_aok = 1'b0; k_dok = 1'b0; k_en = 2'b00;
        tick();

        // reset while in DATA
        begin
            bus_exp_t be;
            be.bus  = {1'b0, 2'b10, 32'h0000_0200, 32'h0, 4'h0};
            be.reqc = 1;
            exp_bus.push_back(be);
        end
        d_en = 2'b01; d_addr = 32'h0000_0200; d_wdata = 32'h0; d_size = 3'b010;
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        d_en = 2'b00;
        @(negedge clk);
        chk("data_state_stall", d_stall, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_req", data_req, 0);
        chk("midrst_rdata", d_rdata, 0);
        chk("midrst_stall", d_stall, 0);
        model_rd = 32'h0;
        tick();
        tick();

        // recovery after reset
        do_txn(2'b01, 32'hBFC0_0000, 32'h0, 3'b010, 4'h0, 0, 0, 32'h0F0F_0F0F, 32'h1FC0_0000);
        d_en = 2'b00;
        tick();
        tick();
        chk("bus_queue_empty", exp_bus.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
